register_bank: RTL

Parametrised bank of NREGS control/status registers behind a simple single-cycle write / registered-read bus. It replaces per-register decode instances with one block that adds read-back, read-only status slots, self-clearing pulse bits, per-register write strobes and an acknowledge/error handshake. It sits between the host bus decoder and the comparator-test datapath, which consumes the flattened register outputs.

---
 rtl/register_bank.sv | 138 +++++++++++++
 1 files changed

// File: rtl/register_bank.sv
// register_bank
//
// Bank of NREGS control/status registers behind a single-cycle write /
// registered-read host bus. Each slot is either a writable register (with
// optional self-clearing pulse bits) or a read-only window onto a status
// input. Every request is answered one cycle later with an ack pulse, an
// err qualifier and, for reads, the registered read data.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   synchronous, active-high reset
//   wr         in   write request qualifier (single cycle)
//   rd         in   read request qualifier (single cycle)
//   adr        in   [ADRSIZE]        bus address, sampled with wr/rd
//   bus_wr     in   [REGSIZE]        write data
//   bus_rd     out  [REGSIZE]        registered read data, holds until next read
//   ack        out  one-cycle completion pulse for any wr and/or rd
//   err        out  qualifies ack: address miss or write to read-only slot
//   regs       out  [NREGS*REGSIZE]  flattened register contents (RO slots = 0)
//   status     in   [NREGS*REGSIZE]  flattened status inputs for RO slots
//   wr_strobe  out  [NREGS]          per-register one-cycle write pulse

module register_bank #(
    parameter int                         ADRSIZE    = 8,
    parameter int                         REGSIZE    = 32,
    parameter int                         NREGS      = 8,
    parameter int                         BASEADR    = 0,
    parameter logic [NREGS*REGSIZE-1:0]   INIT       = '0,
    parameter logic [NREGS-1:0]           RO_MASK    = '0,
    parameter logic [NREGS*REGSIZE-1:0]   PULSE_MASK = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr,
    input  logic                        rd,
    input  logic [ADRSIZE-1:0]          adr,
    input  logic [REGSIZE-1:0]          bus_wr,
    output logic [REGSIZE-1:0]          bus_rd,
    output logic                        ack,
    output logic                        err,
    output logic [NREGS*REGSIZE-1:0]    regs,
    input  logic [NREGS*REGSIZE-1:0]    status,
    output logic [NREGS-1:0]            wr_strobe
);

    // Address is widened by one bit so BASEADR+NREGS never wraps when the
    // bank ends exactly at the top of the address space.
    logic [ADRSIZE:0]                   adr_ext;
    logic [NREGS-1:0]                   sel;
    logic [NREGS-1:0]                   wr_sel;
    logic                               hit;
    logic                               ro_hit;
    logic [NREGS-1:0][REGSIZE-1:0]      rd_val;
    logic [REGSIZE-1:0]                 rd_mux;

    logic [REGSIZE-1:0]                 bus_rd_p1;
    logic                               ack_p1;
    logic                               err_p1;
    logic [NREGS-1:0]                   wr_strobe_p1;

    assign adr_ext = {1'b0, adr};

    // A one-hot compare per slot is equivalent to the range check plus
    // offset decode, and never looks at offset bits beyond the bank.
    assign hit    = |sel;
    assign ro_hit = |(sel & RO_MASK);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_slot
            localparam logic [ADRSIZE:0] SLOT_ADR = (ADRSIZE+1)'(BASEADR + gi);

            assign sel[gi] = (adr_ext == SLOT_ADR);

            if (RO_MASK[gi]) begin : g_ro
                assign wr_sel[gi]                       = 1'b0;
                assign regs[gi*REGSIZE +: REGSIZE]      = '0;
                assign rd_val[gi] = sel[gi] ? status[gi*REGSIZE +: REGSIZE] : '0;
            end else begin : g_rw
                localparam logic [REGSIZE-1:0] INIT_I  = INIT[gi*REGSIZE +: REGSIZE];
                localparam logic [REGSIZE-1:0] PULSE_I = PULSE_MASK[gi*REGSIZE +: REGSIZE];

                logic [REGSIZE-1:0] q_p1;
                logic               unused_status;

                assign unused_status = ^status[gi*REGSIZE +: REGSIZE];
                assign wr_sel[gi]    = wr & sel[gi];

                // Stage p0 -> p1: register storage. Pulse bits are cleared on
                // every cycle the register is not being written.
                always_ff @(posedge clock) begin
                    if (reset) begin
                        q_p1 <= INIT_I;
                    end else if (wr_sel[gi]) begin
                        q_p1 <= bus_wr;
                    end else begin
                        q_p1 <= q_p1 & ~PULSE_I;
                    end
                end

                assign regs[gi*REGSIZE +: REGSIZE] = q_p1;
                // Read sees q_p1 before this cycle's write lands.
                assign rd_val[gi] = sel[gi] ? q_p1 : '0;
            end
        end
    endgenerate

    // At most one slot is selected, so an OR across slots is the read mux.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NREGS; i++) begin
            rd_mux = rd_mux | rd_val[i];
        end
    end

    // Stage p0 -> p1: bus response.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_rd_p1    <= '0;
            ack_p1       <= 1'b0;
            err_p1       <= 1'b0;
            wr_strobe_p1 <= '0;
        end else begin
            ack_p1       <= wr | rd;
            err_p1       <= (wr & (~hit | ro_hit)) | (rd & ~hit);
            wr_strobe_p1 <= wr_sel;
            if (rd) begin
                bus_rd_p1 <= hit ? rd_mux : '0;
            end
        end
    end

    assign bus_rd    = bus_rd_p1;
    assign ack       = ack_p1;
    assign err       = err_p1;
    assign wr_strobe = wr_strobe_p1;

endmodule
